// File: rtl/alu_bus_pkg.sv
// Shared constants, state encoding and flag bit positions for the ALU result bus writer.
package alu_bus_pkg;

  localparam int WIDTH = 4;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    DRV_R,
    DRV_F,
    SEQ_R
  } state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flags nibble builder: overflow, negative, zero, carry from the ALU outputs.
module alu_flag_gen
  import alu_bus_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] res,
  input  logic             cout,
  input  logic             ovf,
  output logic [WIDTH-1:0] flags
);

  always_comb begin
    flags        = '0;
    flags[FLG_C] = cout;
    flags[FLG_Z] = (res == '0);
    flags[FLG_N] = res[WIDTH-1];
    flags[FLG_V] = ovf;
  end

endmodule

// File: rtl/alu_bus_writer.sv
// Captures the ALU result and flags, then drives them onto the shared tri-state data bus
// on write strobes from the microcode controller.
module alu_bus_writer
  import alu_bus_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             grst,
  input  logic             lrst,
  input  logic             ld,
  input  logic [WIDTH-1:0] res,
  input  logic             cout,
  input  logic             ovf,
  input  logic             ws1,
  input  logic             ws2,
  input  logic             wsq,
  inout  wire  [WIDTH-1:0] bus,
  output logic             valid,
  output logic             busy,
  output logic             nack
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] y1_reg, y2_reg;
  logic [WIDTH-1:0] drive_reg, drive_next;
  logic             nack_reg, nack_next;
  logic [WIDTH-1:0] flags_new;
  logic             req_any;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .res   (res),
    .cout  (cout),
    .ovf   (ovf),
    .flags (flags_new)
  );

  assign req_any = ws1 | ws2 | wsq;

  always_comb begin
    state_next = state_reg;
    drive_next = drive_reg;
    nack_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        nack_next = req_any;
        if (ld) state_next = READY;
      end
      READY: begin
        if (wsq) begin
          state_next = SEQ_R;
          drive_next = y1_reg;
        end else if (ws1) begin
          state_next = DRV_R;
          drive_next = y1_reg;
        end else if (ws2) begin
          state_next = DRV_F;
          drive_next = y2_reg;
        end
      end
      DRV_R, DRV_F: begin
        state_next = READY;
        nack_next  = req_any;
      end
      SEQ_R: begin
        // A capture landing on this edge must reach the following flags cycle.
        state_next = DRV_F;
        drive_next = ld ? flags_new : y2_reg;
        nack_next  = req_any;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (grst || lrst) begin
      state_reg <= IDLE;
      y1_reg    <= '0;
      y2_reg    <= '0;
      drive_reg <= '0;
      nack_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      drive_reg <= drive_next;
      nack_reg  <= nack_next;
      if (ld) begin
        y1_reg <= res;
        y2_reg <= flags_new;
      end
    end
  end

  assign busy  = (state_reg == DRV_R) || (state_reg == DRV_F) || (state_reg == SEQ_R);
  assign valid = (state_reg != IDLE);
  assign nack  = nack_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bus_drv
    assign bus[gi] = busy ? drive_reg[gi] : 1'bz;
  end

endmodule

// File: doc/alu_bus_writer.md
Name: alu_bus_writer

Overview:
- Result-side bus writer of the 4-bit ALU. It is the counterpart of the operand-capture registers, which read the shared data bus.
- Captures the ALU result nibble and a flags nibble, then drives them onto the shared tri-state data bus on controller write strobes.
- Sits between the ALU combinational core and the data bus. It is sequenced by the microcode controller.

Parameters:
- WIDTH, 4, data bus, result and flags width. Only 4 is supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- grst  input  1  global reset; synchronous, active-high.
- lrst  input  1  local clear; synchronous, active-high; same effect as grst.
- ld  input  1  capture res, cout and ovf at the next edge.
- res  input  WIDTH  ALU result.
- cout  input  1  ALU carry out.
- ovf  input  1  ALU signed overflow.
- ws1  input  1  request: drive the result nibble for one cycle.
- ws2  input  1  request: drive the flags nibble for one cycle.
- wsq  input  1  request: drive the result, then the flags, on consecutive cycles.
- bus  inout  WIDTH  shared data bus; this block only drives it, and leaves it high-Z otherwise.
- valid  output  1  a captured result is held.
- busy  output  1  the block is driving the bus this cycle.
- nack  output  1  one-cycle pulse: a request was dropped.

Behaviour:
- Reset (grst or lrst sampled high at an edge), in all states including mid-drive:
  - state to IDLE; Y1, Y2 and the drive register to 0.
  - valid=0, busy=0, nack=0; bus goes high-Z from the next cycle.
  - Reset has priority over all other inputs.
- Capture (ld=1 at an edge):
  - Y1 <= res.
  - Y2 <= {ovf, res[3], (res==0), cout}, with bits 3..0 = overflow, negative, zero, carry.
  - valid=1 from the next cycle.
- Drive timing:
  - The bus is driven only from a drive register, which is loaded when a drive state is entered.
  - Bus value = drive register when busy=1; high-Z otherwise. The block never drives the bus in IDLE or READY.
  - Latency: a request sampled at edge N gives bus data during cycle N..N+1, i.e. one cycle after the strobe.
- States:
  - IDLE: valid=0. Any ws1/ws2/wsq → nack pulse, stay IDLE. ld → READY.
  - READY: valid=1. Requests are arbitrated wsq > ws1 > ws2.
    - wsq → SEQ_R, drive register <= Y1.
    - ws1 → DRV_R, drive register <= Y1.
    - ws2 → DRV_F, drive register <= Y2.
  - DRV_R: busy=1 for one cycle, then → READY.
  - DRV_F: busy=1 for one cycle, then → READY.
  - SEQ_R: busy=1; drive register <= Y2; → DRV_F. Result and flags appear back-to-back with no idle cycle.
- Simultaneous ld and request in READY:
  - Capture happens, and the request is honoured.
  - The drive register loads the old Y1/Y2, because it samples register contents before the edge.
- ld during a drive state: Y1/Y2 update, but the in-flight drive data is unchanged. In SEQ_R, the following flags cycle uses the new Y2.
- Requests during DRV_R, DRV_F or SEQ_R: dropped, nack pulsed for one cycle. Requests are not queued.
- Multiple strobes in one cycle: only the highest-priority one is served. The others are silently ignored, with no nack.
- valid is held after drives; results can be re-read any number of times. valid clears only on reset.

Decomposition:
- Package alu_bus_pkg:
  - WIDTH constant.
  - State enum: IDLE, READY, DRV_R, DRV_F, SEQ_R.
  - Flag bit indices: FLG_C=0, FLG_Z=1, FLG_N=2, FLG_V=3.
- One natural sub-module, alu_flag_gen: combinational, builds the flags nibble from res, cout and ovf. The FSM and tri-state driver stay in the top level.

Test Plan:
- Reset then ws1 with no ld → nack=1 for one cycle, bus stays high-Z, valid=0.
- ld with res=4'h0, cout=1, ovf=0, then ws1, then ws2:
  - bus=4'h0 in the cycle after ws1.
  - bus=4'b0011 in the cycle after ws2.
  - Bus is high-Z between them.
- ld with res=4'h9, cout=0, ovf=1, then wsq:
  - bus=4'h9, then 4'b1100 on consecutive cycles; busy=1 for 2 cycles.
  - A ws1 issued in the first busy cycle gives nack=1 and no extra drive.
- In READY with res=4'h9 held, assert ws1, ws2 and wsq together → SEQ_R path only (9 then flags); no nack.
- Assert grst during the SEQ_R cycle → bus high-Z on the next cycle (no flags cycle), valid=0, Y1=Y2=0.
- Hold res=4'h3 in READY, then ld res=4'h5 together with ws1 → bus=4'h3; a later ws1 gives bus=4'h5.
